// File: rtl/prog_loader_if.sv
// Pin/memory-side bundle of the program loader: host handshake in, RAM write port
// and CPU-reset/status out. master = loader, slave = host/memory side.
interface prog_loader_if #(
  parameter int ADDR_W = 4
);
  logic              load_req;
  logic              in_strobe;
  logic [7:0]        in_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we_n;
  logic              ack;
  logic              cpu_rst_n;
  logic              loading;
  logic              done;
  logic [ADDR_W:0]   byte_count;

  modport master (
    input  load_req, in_strobe, in_data,
    output ram_addr, ram_data, ram_we_n, ack, cpu_rst_n, loading, done, byte_count
  );

  modport slave (
    output load_req, in_strobe, in_data,
    input  ram_addr, ram_data, ram_we_n, ack, cpu_rst_n, loading, done, byte_count
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: writes host bytes into data RAM over a strobe/ack handshake
// while holding the CPU in reset. Every output is registered from the next state.
module prog_loader #(
  parameter int RAM_BYTES   = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  prog_loader_if.master  bus
);
  typedef enum logic [2:0] {IDLE, WAIT_STB, WRITE, WAIT_REL, DONE} state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(RAM_BYTES);

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] req_pipe, stb_pipe;
  logic                   stb_s_d;
  logic                   req_s, stb_s, stb_rise;

  logic [ADDR_W-1:0]      addr_nx;
  logic [7:0]             data_nx;
  logic [ADDR_W:0]        cnt_nx;
  logic                   ack_nx, we_n_nx;

  assign req_s    = req_pipe[SYNC_STAGES-1];
  assign stb_s    = stb_pipe[SYNC_STAGES-1];
  assign stb_rise = stb_s & ~stb_s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pipe <= '0;
      stb_pipe <= '0;
      stb_s_d  <= 1'b0;
    end else begin
      req_pipe <= {req_pipe[SYNC_STAGES-2:0], bus.load_req};
      stb_pipe <= {stb_pipe[SYNC_STAGES-2:0], bus.in_strobe};
      stb_s_d  <= stb_s;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = bus.ram_addr;
    data_nx  = bus.ram_data;
    cnt_nx   = bus.byte_count;
    ack_nx   = 1'b0;
    we_n_nx  = 1'b1;
    case (state)
      IDLE: begin
        if (req_s) begin
          state_nx = WAIT_STB;
          addr_nx  = '0;
          cnt_nx   = '0;
        end
      end
      WAIT_STB: begin
        if (!req_s) begin
          state_nx = IDLE;
        end else if (stb_rise) begin
          state_nx = WRITE;
          data_nx  = bus.in_data;
          we_n_nx  = 1'b0;
          ack_nx   = 1'b1;
        end
      end
      WRITE: begin
        state_nx = WAIT_REL;
        ack_nx   = 1'b1;
        cnt_nx   = (bus.byte_count == FULL) ? FULL : bus.byte_count + 1'b1;
      end
      WAIT_REL: begin
        // abort on a dropped request is deferred until we are back in WAIT_STB
        if (stb_s) begin
          ack_nx = 1'b1;
        end else if (bus.byte_count == FULL) begin
          state_nx = DONE;
        end else begin
          state_nx = WAIT_STB;
          addr_nx  = bus.ram_addr + 1'b1;
        end
      end
      DONE: begin
        if (!req_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.ram_addr   <= '0;
      bus.ram_data   <= '0;
      bus.ram_we_n   <= 1'b1;
      bus.ack        <= 1'b0;
      bus.cpu_rst_n  <= 1'b0;
      bus.loading    <= 1'b0;
      bus.done       <= 1'b0;
      bus.byte_count <= '0;
    end else begin
      state          <= state_nx;
      bus.ram_addr   <= addr_nx;
      bus.ram_data   <= data_nx;
      bus.ram_we_n   <= we_n_nx;
      bus.ack        <= ack_nx;
      bus.cpu_rst_n  <= (state_nx == IDLE);
      bus.loading    <= (state_nx != IDLE);
      bus.done       <= (state_nx == DONE);
      bus.byte_count <= cnt_nx;
    end
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the 8-bit CPU. It accepts program bytes from external pins over a four-phase strobe/ack handshake and writes them into the 16-byte data memory at consecutive addresses starting at 0. While a load session is active it holds the CPU core in reset; it releases the core once the host drops the load request. It sits between the top-level input pins and the memory write port, as an alternative writer to the CPU's own address/data path.

## Interface
Parameters:
- `RAM_BYTES`, 16, number of bytes per full load; must be a power of two.
- `ADDR_W`, 4, address width, equal to log2(`RAM_BYTES`).
- `SYNC_STAGES`, 2, flip-flop depth of the input synchronizers; minimum 2.

Ports:
- `clk`  in  1  single system clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load_req`  in  1  asynchronous level from the host; high means a load session is requested.
- `in_strobe`  in  1  asynchronous host strobe; a rising edge means `in_data` is valid.
- `in_data`  in  8  program byte; the host keeps it stable from before `in_strobe` rises until `ack` is high.
- `ram_addr`  out  `ADDR_W`  write address.
- `ram_data`  out  8  write data, registered.
- `ram_we_n`  out  1  write strobe, active-low, asserted for one cycle per byte.
- `ack`  out  1  handshake acknowledge to the host.
- `cpu_rst_n`  out  1  reset to the CPU core, active-low.
- `loading`  out  1  high while a session is active (any state other than IDLE).
- `done`  out  1  high when all `RAM_BYTES` bytes have been written.
- `byte_count`  out  `ADDR_W+1`  number of bytes written in the current session, 0..`RAM_BYTES`.

## Operation
- `load_req` and `in_strobe` each pass through a `SYNC_STAGES` synchronizer; the synchronized outputs are `req_s` and `stb_s`.
- Strobe edge detect: `stb_rise = stb_s & ~stb_s_d`, where `stb_s_d` is `stb_s` delayed by one flop.
- IDLE:
  - `cpu_rst_n` = 1; `ack` = 0.
  - If `req_s` = 1: go to WAIT_STB, set `ram_addr` = 0 and `byte_count` = 0, and drive `cpu_rst_n` = 0.
- WAIT_STB:
  - If `req_s` = 0: abort to IDLE. Bytes already written are kept; unwritten locations are untouched.
  - Otherwise, if `stb_rise`: register `ram_data` <= `in_data` and go to WRITE.
- WRITE:
  - `ram_we_n` = 0 and `ack` = 1 for this one cycle.
  - Increment `byte_count`, then go to WAIT_REL.
- WAIT_REL:
  - Hold `ack` = 1 until `stb_s` = 0.
  - Then, if `byte_count` = `RAM_BYTES`: go to DONE.
  - Otherwise increment `ram_addr` and go to WAIT_STB.
  - `req_s` is ignored in this state; the abort is taken on return to WAIT_STB.
- DONE:
  - `done` = 1, `ack` = 0, `cpu_rst_n` stays 0.
  - If `req_s` = 0: go to IDLE; the CPU is released.
  - Further strobes are ignored; no writes occur.
- Arithmetic:
  - `ram_addr` never wraps within a session; the last address written is `RAM_BYTES-1`.
  - `byte_count` saturates at `RAM_BYTES`.
- Only one write happens per strobe rising edge. A strobe that is already high when WAIT_STB is entered does not write; the host must lower it and raise it again.

## Timing
- Reset values:
  - state IDLE; all synchronizer flops 0.
  - `ram_addr` 0, `ram_data` 0, `ram_we_n` 1, `ack` 0.
  - `cpu_rst_n` 0, `loading` 0, `done` 0, `byte_count` 0.
- After `rst_n` deasserts, `cpu_rst_n` rises on the first clock edge while in IDLE with `req_s` = 0. This gives the CPU one cycle of reset stretch.
- All outputs are registered; none is combinational from an input.
- Strobe latency:
  - Let edge k be the first edge that samples `in_strobe` high.
  - `ram_we_n` falls and `ack` rises at edge k+`SYNC_STAGES`, and `ram_we_n` returns high one edge later.
  - `ram_addr` and `ram_data` are stable for the whole cycle in which `ram_we_n` is low.
- Release latency:
  - Let edge m be the first edge that samples `in_strobe` low.
  - `ack` falls at edge m+`SYNC_STAGES`; `ram_addr` increments on that same edge.
- Request latency:
  - `cpu_rst_n` falls `SYNC_STAGES` edges after `load_req` is first sampled high.
  - `cpu_rst_n` rises `SYNC_STAGES` edges after `load_req` is first sampled low, from either DONE or an abort.
- Asserting `rst_n` mid-session stops immediately: `ram_we_n` goes to 1 asynchronously and all state returns to reset values.

## Test plan
- Full load: `load_req`=1, then 16 handshakes with bytes 0x10..0x1F.
  - Expect 16 single-cycle `ram_we_n` pulses at addresses 0..15 with data 0x10..0x1F.
  - Then `done`=1, `byte_count`=16, `cpu_rst_n`=0.
  - Drop `load_req` → `cpu_rst_n`=1 after 2 cycles.
- Latency check: raise `in_strobe` one cycle before an edge → `ram_we_n` is low exactly 2 edges later, for exactly 1 cycle, with `ack` rising on the same edge.
- Abort: 5 bytes (0xA0..0xA4), then drop `load_req` in WAIT_STB → IDLE, `byte_count` reads 0 after a new request, addresses 5..15 are never written, `cpu_rst_n` returns to 1.
- Held strobe: `in_strobe` already high when `load_req` rises → no write until `in_strobe` goes low and then high again. Keeping `in_strobe` high for 20 cycles produces exactly one write.
- Extra strobes in DONE: after a full load, 3 more handshakes → `ram_we_n` stays 1, `ack` stays 0, `ram_addr` stays 15.
- Reset mid-write: assert `rst_n`=0 in the same cycle as `ram_we_n`=0 → `ram_we_n`=1 asynchronously, `cpu_rst_n`=0, state IDLE, `ram_addr`=0.
